instruction_fetch: RTL and testbench

Instruction fetch stage feeding the decode stage, where the 32-bit instruction word drives the immediate generator and control decode. Owns the program counter, issues single-outstanding word reads to instruction memory over a req/ack interface, and holds each fetched instruction in an output register until decode accepts it with a valid/ready handshake. A redirect input from execute (taken branch, JAL, JALR) reloads the PC and discards stale fetches.

---
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and holds each fetched instruction until decode accepts it. Redirects discard stale fetches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        unused_bits;

  assign target      = {redirect_pc_i[31:2], 2'b00};
  assign pc_inc      = pc + 32'd4;
  assign unused_bits = ^redirect_pc_i[1:0];

  // addr is separate from pc so the in-flight address stays stable in DROP while pc moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      addr   <= RESET_PC;
      instr  <= '0;
      pc_out <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_i) begin
            pc <= target;
            if (mem_ack_i) begin
              addr  <= target;
              state <= FETCH;
            end else begin
              state <= DROP;
            end
          end else if (mem_ack_i) begin
            instr  <= mem_rdata_i;
            pc_out <= pc;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc    <= target;
            addr  <= target;
            state <= FETCH;
          end else if (instr_ready_i) begin
            pc    <= pc_inc;
            addr  <= pc_inc;
            state <= FETCH;
          end
        end
        DROP: begin
          if (redirect_i) begin
            pc <= target;
            if (mem_ack_i) begin
              addr  <= target;
              state <= FETCH;
            end
          end else if (mem_ack_i) begin
            addr  <= pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
          addr  <= pc;
        end
      endcase
    end
  end

  assign mem_req_o     = (state == FETCH) || (state == DROP);
  assign mem_addr_o    = addr;
  assign instr_valid_o = (state == HOLD);
  assign instr_o       = instr;
  assign pc_o          = pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a hand-driven memory responder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is cycle 0 of an outstanding request; ack arrives at cycle lat.
  task automatic mem_wait(input int unsigned lat, input logic [31:0] data);
    mem_ack_i = 1'b0;
    for (int unsigned i = 0; i < lat; i++) step();
    mem_ack_i   = 1'b1;
    mem_rdata_i = data;
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hxxxx_xxxx;
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL reset_addr got=%h exp=00000100", mem_addr_o); end
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", mem_req_o); end
    checks++; if (instr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL reset_outs instr=%h pc=%h exp=0/0", instr_o, pc_o); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    mem_wait(1, 32'h0050_0093);
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", instr_valid_o); end
    checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got=%h exp=00500093", instr_o); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL basic_pc got=%h exp=00000100", pc_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_hold got=%b exp=0", mem_req_o); end
    accept();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin errors++; $display("FAIL basic_next req=%b addr=%h exp=1/00000104", mem_req_o, mem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", instr_valid_o); end
  endtask

  task automatic test_stall();
    mem_wait(1, 32'h1111_1111);
    for (int unsigned c = 0; c < 5; c++) begin
      step();
      checks++;
      if (instr_valid_o !== 1'b1 || mem_req_o !== 1'b0 || instr_o !== 32'h1111_1111 || pc_o !== 32'h104) begin
        errors++;
        $display("FAIL stall_cycle%0d valid=%b req=%b instr=%h pc=%h exp=1/0/11111111/00000104",
                 c, instr_valid_o, mem_req_o, instr_o, pc_o);
      end
    end
    accept();
    checks++; if (mem_addr_o !== 32'h108) begin errors++; $display("FAIL stall_release_addr got=%h exp=00000108", mem_addr_o); end
  endtask

  task automatic test_redirect_hold();
    mem_wait(1, 32'h2222_2222);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203; instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rdh_valid got=%b exp=0", instr_valid_o); end
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin errors++; $display("FAIL rdh_addr req=%b addr=%h exp=1/00000200", mem_req_o, mem_addr_o); end
    mem_wait(1, 32'h3333_3333);
    checks++; if (pc_o !== 32'h200 || instr_o !== 32'h3333_3333) begin errors++; $display("FAIL rdh_deliver pc=%h instr=%h exp=00000200/33333333", pc_o, instr_o); end
    accept();
    checks++; if (mem_addr_o !== 32'h204) begin errors++; $display("FAIL rdh_next got=%h exp=00000204", mem_addr_o); end
  endtask

  task automatic test_redirect_fetch();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    step();
    redirect_i = 1'b0;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h204) begin errors++; $display("FAIL rdf_drop_addr req=%b addr=%h exp=1/00000204", mem_req_o, mem_addr_o); end
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h800;
    step();
    redirect_i = 1'b0;
    checks++; if (mem_addr_o !== 32'h204 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL rdf_drop2 addr=%h valid=%b exp=00000204/0", mem_addr_o, instr_valid_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    step();
    mem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h800) begin errors++; $display("FAIL rdf_restart valid=%b req=%b addr=%h exp=0/1/00000800", instr_valid_o, mem_req_o, mem_addr_o); end
    mem_wait(4, 32'h4444_4444);
    checks++; if (pc_o !== 32'h800 || instr_o !== 32'h4444_4444) begin errors++; $display("FAIL rdf_deliver pc=%h instr=%h exp=00000800/44444444", pc_o, instr_o); end
    accept();
  endtask

  task automatic test_redirect_ack();
    redirect_i = 1'b1; redirect_pc_i = 32'h900; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0001;
    step();
    redirect_i = 1'b0; mem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'h900) begin errors++; $display("FAIL rda_fetch valid=%b addr=%h exp=0/00000900", instr_valid_o, mem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'hA00;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'hB00; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0002;
    step();
    redirect_i = 1'b0; mem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'hB00) begin errors++; $display("FAIL rda_drop valid=%b req=%b addr=%h exp=0/1/00000b00", instr_valid_o, mem_req_o, mem_addr_o); end
    mem_wait(1, 32'h5555_5555);
    checks++; if (pc_o !== 32'hB00 || instr_o !== 32'h5555_5555) begin errors++; $display("FAIL rda_deliver pc=%h instr=%h exp=00000b00/55555555", pc_o, instr_o); end
    accept();
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0003;
    step();
    redirect_i = 1'b0; mem_ack_i = 1'b0;
    checks++; if (mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", mem_addr_o); end
    mem_wait(1, 32'h6666_6666);
    checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc_o); end
    accept();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next req=%b addr=%h exp=1/00000000", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_async_reset();
    mem_wait(1, 32'h7777_7777);
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", instr_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'h100 || pc_o !== 32'h0) begin errors++; $display("FAIL areset_immediate valid=%b addr=%h pc=%h exp=0/00000100/00000000", instr_valid_o, mem_addr_o, pc_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0004;
    step();
    mem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL areset_ack_ignored got=%b exp=0", instr_valid_o); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL areset_restart req=%b addr=%h exp=1/00000100", mem_req_o, mem_addr_o); end
    mem_wait(1, 32'h8888_8888);
    checks++; if (pc_o !== 32'h100 || instr_o !== 32'h8888_8888) begin errors++; $display("FAIL areset_deliver pc=%h instr=%h exp=00000100/88888888", pc_o, instr_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_hold();
    test_redirect_fetch();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
